// File: rtl/sram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl_if
// Brief    : Stream-in / stream-out / SRAM-port bundle for sram_fifo_ctrl.
// Revision : 1.0
// ============================================================================
interface sram_fifo_ctrl_if #(
    parameter int WIDTH    = 128,
    parameter int NUM_ROWS = 4096
);
    localparam int AddressWidth = $clog2(NUM_ROWS);
    localparam int CountWidth   = $clog2(NUM_ROWS + 3);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [CountWidth-1:0]   count;
    logic                    sram_REB;
    logic                    sram_WEB;
    logic [AddressWidth-1:0] sram_AA;
    logic [AddressWidth-1:0] sram_AB;
    logic [WIDTH-1:0]        sram_D;
    logic [WIDTH-1:0]        sram_M;
    logic [WIDTH-1:0]        sram_Q;

    // master: the FIFO controller; slave: producer, consumer and macro
    modport master (
        input  in_valid, in_data, out_ready, sram_Q,
        output in_ready, out_valid, out_data, count,
               sram_REB, sram_WEB, sram_AA, sram_AB, sram_D, sram_M
    );

    modport slave (
        output in_valid, in_data, out_ready, sram_Q,
        input  in_ready, out_valid, out_data, count,
               sram_REB, sram_WEB, sram_AA, sram_AB, sram_D, sram_M
    );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl
// Brief    : Ready/valid FIFO on a dual-port SRAM macro with a 2-entry output
//            buffer hiding the macro's one-cycle read latency.
// Revision : 1.0
// ============================================================================
module sram_fifo_ctrl #(
    parameter int WIDTH    = 128,
    parameter int NUM_ROWS = 4096
) (
    input  logic             clk,
    input  logic             rst,
    sram_fifo_ctrl_if.master if_fifo
);
    localparam int c_AW = $clog2(NUM_ROWS);
    localparam int c_CW = $clog2(NUM_ROWS + 3);
    localparam logic [c_AW-1:0] c_LAST_ROW = c_AW'(NUM_ROWS - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(NUM_ROWS);

    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_sram_cnt;
    logic             r_rd_pend;
    logic [WIDTH-1:0] r_ob0;
    logic [WIDTH-1:0] r_ob1;
    logic [1:0]       r_ob_cnt;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_rd_issue;
    logic [1:0]       w_ob_after_pop;
    logic [2:0]       w_occupancy;

    assign w_in_ready     = !rst && (r_sram_cnt != c_FULL);
    assign w_push         = if_fifo.in_valid && w_in_ready;
    assign w_pop          = (r_ob_cnt != 2'd0) && if_fifo.out_ready;
    assign w_ob_after_pop = r_ob_cnt - {1'b0, w_pop};
    // Words that will sit in the buffer once the in-flight read lands
    assign w_occupancy    = {1'b0, w_ob_after_pop} + {2'b00, r_rd_pend};
    assign w_rd_issue     = (r_sram_cnt != '0) && (w_occupancy < 3'd2);

    always_ff @(posedge clk or posedge rst) begin : p_wptr
        if (rst) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= (r_wptr == c_LAST_ROW) ? '0 : r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_rptr
        if (rst) begin
            r_rptr <= '0;
        end else if (w_rd_issue) begin
            r_rptr <= (r_rptr == c_LAST_ROW) ? '0 : r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_sram_cnt
        if (rst) begin
            r_sram_cnt <= '0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_sram_cnt <= r_sram_cnt + c_CW'(w_push) - c_CW'(w_rd_issue);
            r_rd_pend  <= w_rd_issue;
        end
    end

    // Returning read data lands right behind whatever survives this cycle's pop
    always_ff @(posedge clk or posedge rst) begin : p_out_buf
        if (rst) begin
            r_ob0    <= '0;
            r_ob1    <= '0;
            r_ob_cnt <= 2'd0;
        end else begin
            if (w_pop) begin
                r_ob0 <= r_ob1;
            end
            if (r_rd_pend) begin
                if (w_ob_after_pop == 2'd0) begin
                    r_ob0 <= if_fifo.sram_Q;
                end else begin
                    r_ob1 <= if_fifo.sram_Q;
                end
            end
            r_ob_cnt <= w_ob_after_pop + {1'b0, r_rd_pend};
        end
    end

    assign if_fifo.in_ready  = w_in_ready;
    assign if_fifo.out_valid = (r_ob_cnt != 2'd0);
    assign if_fifo.out_data  = r_ob0;
    assign if_fifo.count     = r_sram_cnt + c_CW'(r_rd_pend) + c_CW'(r_ob_cnt);
    assign if_fifo.sram_REB  = !w_rd_issue;
    assign if_fifo.sram_WEB  = !w_push;
    assign if_fifo.sram_AA   = r_wptr;
    assign if_fifo.sram_AB   = r_rptr;
    assign if_fifo.sram_D    = if_fifo.in_data;
    assign if_fifo.sram_M    = '0;

    a_ob_bound : assert property (@(posedge clk) disable iff (rst)
        r_ob_cnt <= 2'd2);
    a_sram_bound : assert property (@(posedge clk) disable iff (rst)
        r_sram_cnt <= c_FULL);
    a_no_rw_same_row : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_rd_issue && (r_wptr == r_rptr)));
endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_ctrl
// Brief    : Scoreboard bench: an 8-row and a 5-row controller, each on a
//            behavioural macro model. Revision : 1.0
// ============================================================================
module tb_sram_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_fifo_ctrl_if #(.WIDTH(16), .NUM_ROWS(8)) b8 ();
    sram_fifo_ctrl_if #(.WIDTH(16), .NUM_ROWS(5)) b5 ();

    sram_fifo_ctrl #(.WIDTH(16), .NUM_ROWS(8)) u_dut8 (.clk(clk), .rst(rst), .if_fifo(b8.master));
    sram_fifo_ctrl #(.WIDTH(16), .NUM_ROWS(5)) u_dut5 (.clk(clk), .rst(rst), .if_fifo(b5.master));

    // Macro models: write on WEB low, registered read on REB low, Q held otherwise
    logic [15:0] mem8 [0:7];
    logic [15:0] mem5 [0:4];
    always @(posedge clk) begin
        if (!b8.sram_WEB) mem8[b8.sram_AA] <= b8.sram_D;
        if (!b8.sram_REB) b8.sram_Q <= mem8[b8.sram_AB];
        if (!b5.sram_WEB && b5.sram_AA <= 3'd4) mem5[b5.sram_AA] <= b5.sram_D;
        if (!b5.sram_REB && b5.sram_AB <= 3'd4) b5.sram_Q <= mem5[b5.sram_AB];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- 8-row monitor: scoreboard + occupancy model ------------
    logic [15:0] q8 [$];
    int  m_sram, m_pend, m_ob, m_wp, m_rp;
    bit  p8, o8, i8;
    logic [15:0] exp8;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_sram = 0; m_pend = 0; m_ob = 0; m_wp = 0; m_rp = 0;
            q8.delete();
        end else begin
            p8 = b8.in_valid && b8.in_ready;
            o8 = b8.out_valid && b8.out_ready;
            i8 = !b8.sram_REB;
            check_val("in_ready8", b8.in_ready, m_sram != 8);
            check_val("out_valid8", b8.out_valid, m_ob != 0);
            check_val("count8_model", b8.count, m_sram + m_pend + m_ob);
            check_val("count8_sb", b8.count, q8.size());
            check_val("reb8_rule", b8.sram_REB,
                      !((m_sram != 0) && (m_ob + m_pend - int'(o8) < 2)));
            check_val("web8", b8.sram_WEB, !p8);
            check_val("aa8", b8.sram_AA, m_wp);
            check_val("ab8", b8.sram_AB, m_rp);
            check_val("m8", b8.sram_M, 16'h0);
            check_val("ob8_le2", m_ob <= 2, 1'b1);
            if (!b8.sram_REB && !b8.sram_WEB)
                check_val("aa8_ne_ab8", b8.sram_AA != b8.sram_AB, 1'b1);
            if (o8) begin
                check_val("pop8_expected", q8.size() != 0, 1'b1);
                if (q8.size() != 0) begin
                    exp8 = q8.pop_front();
                    check_val("data8", b8.out_data, exp8);
                end
            end
            if (p8) q8.push_back(b8.in_data);
            m_ob   = m_ob - int'(o8) + m_pend;
            m_pend = int'(i8);
            m_sram = m_sram + int'(p8) - int'(i8);
            if (p8) m_wp = (m_wp == 7) ? 0 : m_wp + 1;
            if (i8) m_rp = (m_rp == 7) ? 0 : m_rp + 1;
        end
    end

    // ---------------- 5-row monitor: scoreboard + address range -------------
    logic [15:0] q5 [$];
    int popped5;
    bit p5, o5;
    logic [15:0] exp5;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            q5.delete();
            popped5 = 0;
        end else begin
            p5 = b5.in_valid && b5.in_ready;
            o5 = b5.out_valid && b5.out_ready;
            check_val("count5_sb", b5.count, q5.size());
            check_val("web5", b5.sram_WEB, !p5);
            check_val("aa5_range", b5.sram_AA <= 3'd4, 1'b1);
            check_val("ab5_range", b5.sram_AB <= 3'd4, 1'b1);
            if (o5) begin
                check_val("pop5_expected", q5.size() != 0, 1'b1);
                if (q5.size() != 0) begin
                    exp5 = q5.pop_front();
                    check_val("data5", b5.out_data, exp5);
                end
                popped5++;
            end
            if (p5) q5.push_back(b5.in_data);
        end
    end

    task automatic drain8(input string tag);
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 40 && b8.count != 0; i++) begin
            @(posedge clk); #1;
        end
        check_val(tag, b8.count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int acc, sent;
    bit done, acc5;

    initial begin
        b8.in_valid = 1'b1; b8.in_data = 16'h0; b8.out_ready = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = 16'h0; b5.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", b8.in_ready, 1'b0);
        check_val("rst_out_valid", b8.out_valid, 1'b0);
        check_val("rst_out_data", b8.out_data, 16'h0);
        check_val("rst_count", b8.count, 0);
        check_val("rst_reb", b8.sram_REB, 1'b1);
        check_val("rst_web", b8.sram_WEB, 1'b1);
        check_val("rst_aa", b8.sram_AA, 0);
        check_val("rst_ab", b8.sram_AB, 0);
        check_val("rst_m", b8.sram_M, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; b8.in_valid = 1'b0;
        #1 check_val("in_ready_after_rst", b8.in_ready, 1'b1);

        // Back-to-back 1..5: first word visible three cycles after it is offered
        for (int k = 0; k < 10; k++) begin
            b8.in_valid  = (k < 5);
            b8.in_data   = 16'(k + 1);
            b8.out_ready = 1'b1;
            @(posedge clk); #1;
            check_val($sformatf("t1_out_valid_k%0d", k), b8.out_valid, (k >= 2 && k <= 6));
            if (k == 2) check_val("t1_first_word", b8.out_data, 16'h1);
        end
        check_val("t1_count_empty", b8.count, 0);

        // Fill with the consumer stalled: 8 rows + 2 buffered
        b8.out_ready = 1'b0; b8.in_valid = 1'b1; b8.in_data = 16'h200;
        acc = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!b8.in_ready) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                acc++;
                b8.in_data = 16'h200 + 16'(acc);
            end
        end
        check_val("t2_accepted_until_full", acc, 10);
        check_val("t2_count_full", b8.count, 10);
        repeat (4) begin
            @(posedge clk); #1;
            check_val("t2_in_ready_held_low", b8.in_ready, 1'b0);
            check_val("t2_count_held", b8.count, 10);
        end
        drain8("t2_drain");

        // Steady push and pop each cycle
        b8.out_ready = 1'b1; b8.in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b8.in_data = 16'h300 + 16'(k);
            #1;
            if (k >= 3) begin
                check_val("t3_count_const", b8.count, 3);
                check_val("t3_reb_low", b8.sram_REB, 1'b0);
                check_val("t3_web_low", b8.sram_WEB, 1'b0);
                check_val("t3_aa_ne_ab", b8.sram_AA != b8.sram_AB, 1'b1);
            end
            @(posedge clk); #1;
        end
        drain8("t3_drain");

        // Full-rate input against a consumer that accepts every other cycle
        b8.in_valid = 1'b1; b8.in_data = 16'h400; acc = 0;
        for (int i = 0; i < 40; i++) begin
            b8.out_ready = i[0];
            done = b8.in_ready;
            @(posedge clk); #1;
            if (done) begin
                acc++;
                b8.in_data = 16'h400 + 16'(acc);
            end
            check_val("t4_count_bound", b8.count <= 10, 1'b1);
        end
        drain8("t4_drain");

        // Reset with six words queued and a read in flight
        b8.out_ready = 1'b0; b8.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b8.in_data = 16'h600 + 16'(i);
            @(posedge clk); #1;
        end
        b8.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("t5_count_seven", b8.count, 7);
        b8.out_ready = 1'b1;
        #1 check_val("t5_read_issued", b8.sram_REB, 1'b0);
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        check_val("t5_count_six", b8.count, 6);
        #1 rst = 1'b1;
        #1;
        check_val("t5_rst_count", b8.count, 0);
        check_val("t5_rst_out_valid", b8.out_valid, 1'b0);
        check_val("t5_rst_in_ready", b8.in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_val("t5_rel_count", b8.count, 0);
        check_val("t5_rel_out_valid", b8.out_valid, 1'b0);
        check_val("t5_rel_in_ready", b8.in_ready, 1'b1);
        b8.in_valid = 1'b1; b8.in_data = 16'h00AA; b8.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            b8.in_valid = 1'b0;
            check_val($sformatf("t5_aa_valid_k%0d", k), b8.out_valid, (k == 2));
            if (k == 2) check_val("t5_aa_data", b8.out_data, 16'h00AA);
        end

        // Wrap-around on the 5-row instance with random handshakes
        sent = 0; b5.in_data = 16'h500;
        for (int i = 0; i < 600 && popped5 < 23; i++) begin
            b5.in_valid  = (sent < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            b5.out_ready = 1'($urandom_range(0, 1));
            acc5 = b5.in_valid && b5.in_ready;
            @(posedge clk); #1;
            if (acc5) begin
                sent++;
                b5.in_data = 16'h500 + 16'(sent);
            end
        end
        b5.in_valid = 1'b0;
        check_val("t6_sent", sent, 23);
        check_val("t6_popped", popped5, 23);
        check_val("t6_count_empty", b5.count, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
